// File: rtl/am2904_pkg.sv
// Shared definitions for the Am2904 shift sequencer: FSM states, shift and
// condition codes, and the bit layout of the 13-bit Am2904 instruction.
package am2904_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PREP  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Am2904 shift codes (I[10:6])
    localparam logic [4:0] SH_DN_ZERO = 5'o00;
    localparam logic [4:0] SH_UP_ZERO = 5'o22;
    localparam logic [4:0] SH_UP_ROT  = 5'o32;

    // Am2904 condition codes (I[5:0])
    localparam logic [5:0] CT_NONE = 6'h00;
    localparam logic [5:0] CT_MN   = 6'h2e;
    localparam logic [5:0] CT_NMN  = 6'h2f;

    localparam int I_W        = 13;
    localparam int I_CIN_LSB  = 11;
    localparam int I_OP_LSB   = 6;
    localparam int I_COND_LSB = 0;

    function automatic logic [I_W-1:0] am2904Instr(input logic [1:0] cin,
                                                    input logic [4:0] op,
                                                    input logic [5:0] cond);
        logic [I_W-1:0] instr;
        instr = '0;
        instr[I_CIN_LSB +: 2]  = cin;
        instr[I_OP_LSB +: 5]   = op;
        instr[I_COND_LSB +: 6] = cond;
        return instr;
    endfunction

endpackage

// File: rtl/am2904_shift_ctl_cnt.sv
// Shift bookkeeping: loadable down-counter of remaining shifts with a zero
// flag, and an up-counter of shifts actually performed.
module shift_ctl_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [CNT_W-1:0] loadVal,
    output logic             zero,
    output logic [CNT_W-1:0] shifted
);

    logic [CNT_W-1:0] remaining;

    assign zero = (remaining == '0);

    // Stepping is gated by the zero flag so neither counter can wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining <= '0;
            shifted   <= '0;
        end else if (load) begin
            remaining <= loadVal;
            shifted   <= '0;
        end else if (step && !zero) begin
            remaining <= remaining - 1'b1;
            shifted   <= shifted + 1'b1;
        end
    end

endmodule

// File: rtl/am2904_shift_ctl.sv
// Multi-cycle shift sequencer driving the Am2904 and 2901 slices.
// Optional SHIFT_CTL_USR_SAVE_EN adds a PREP cycle saving MSR into uSR.
module am2904_shift_ctl
    import am2904_pkg::*;
#(
    parameter int         CNT_W   = 6,
    parameter logic [1:0] CIN_SEL = 2'b00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [CNT_W-1:0] req_count,
    input  logic             req_norm,
    input  logic [5:0]       req_cond,
    input  logic             ct,
    output logic [12:0]      I,
    output logic             nSE,
    output logic             nCEm,
    output logic             nCEu,
    output logic             nOEct,
    output logic             alu_we,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] shifted,
    output state_t           stateDbg
);

    // Handshake: a request is taken on a rising edge where req_valid and
    // req_ready are both 1; req_ready is 1 only in IDLE, so requests
    // presented while busy (including the DONE cycle) are not captured.

    state_t     state, stateNext;
    logic [4:0] opQ;
    logic [5:0] condQ;
    logic       normQ;
    logic       load;
    logic       step;
    logic       cntZero;

    shift_ctl_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .step    (step),
        .loadVal (req_count),
        .zero    (cntZero),
        .shifted (shifted)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            opQ   <= '0;
            condQ <= '0;
            normQ <= 1'b0;
        end else begin
            state <= stateNext;
            if (load) begin
                opQ   <= req_op;
                condQ <= req_cond;
                normQ <= req_norm;
            end
        end
    end

    always_comb begin
        stateNext = state;
        req_ready = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        I         = '0;
        nSE       = 1'b1;
        nCEm      = 1'b1;
        nCEu      = 1'b1;
        nOEct     = 1'b1;
        alu_we    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    load = 1'b1;
`ifdef SHIFT_CTL_USR_SAVE_EN
                    stateNext = PREP;
`else
                    stateNext = SHIFT;
`endif
                end
            end
`ifdef SHIFT_CTL_USR_SAVE_EN
            PREP: begin
                I         = am2904Instr(CIN_SEL, SH_DN_ZERO, CT_NONE);
                nCEu      = 1'b0;
                stateNext = SHIFT;
            end
`endif
            SHIFT: begin
                I     = am2904Instr(CIN_SEL, opQ, condQ);
                nOEct = ~normQ;
                // ct is judged before this cycle's shift is allowed
                if ((normQ && ct) || cntZero) begin
                    stateNext = DONE;
                end else begin
                    nSE    = 1'b0;
                    alu_we = 1'b1;
                    step   = 1'b1;
                end
            end
            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign stateDbg = state;

endmodule

// File: tb/tb_am2904_shift_ctl.sv
// Randomized self-checking bench for am2904_shift_ctl against a per-request
// reference (expected shift count and done latency from the request alone).
module tb_am2904_shift_ctl;
  import am2904_pkg::*;

  localparam int CNT_W = 6;
  localparam logic [1:0] CIN = 2'b00;
`ifdef SHIFT_CTL_USR_SAVE_EN
  localparam int SHIFT_BASE = 2;
`else
  localparam int SHIFT_BASE = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [4:0] req_op = '0;
  logic [CNT_W-1:0] req_count = '0;
  logic req_norm = 1'b0;
  logic [5:0] req_cond = '0;
  logic ct = 1'b0;
  logic [12:0] i_bus;
  logic n_se, n_ce_m, n_ce_u, n_oe_ct, alu_we, busy, done;
  logic [CNT_W-1:0] shifted;
  state_t state_dbg;

  int n_vectors = 0;
  int n_miscompares = 0;
  logic [CNT_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  am2904_shift_ctl #(.CNT_W(CNT_W), .CIN_SEL(CIN)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_count(req_count), .req_norm(req_norm), .req_cond(req_cond),
    .ct(ct), .I(i_bus), .nSE(n_se), .nCEm(n_ce_m), .nCEu(n_ce_u), .nOEct(n_oe_ct),
    .alu_we(alu_we), .busy(busy), .done(done), .shifted(shifted), .stateDbg(state_dbg)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_junk();
    req_op = 5'($urandom);
    req_count = CNT_W'($urandom);
    req_norm = 1'($urandom);
    req_cond = 6'($urandom);
  endtask

  // Caller is positioned just after a falling edge; returns the same way.
  task automatic run_shift(input logic [4:0] op, input logic [CNT_W-1:0] cnt,
                           input logic norm, input logic [5:0] cond,
                           input int ct_at, input bit hold);
    int w, c, idx, done_at, strobes, proto_err, exp_n;
    logic [CNT_W-1:0] got_shifted, exp_shifted;
    w = 0;
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_eq("ready_before_req", {31'd0, req_ready}, 32'd1);
    exp_n = (norm && ct_at < int'(cnt)) ? ct_at : int'(cnt);
    exp_q.push_back(CNT_W'(exp_n));
    req_op = op; req_count = cnt; req_norm = norm; req_cond = cond;
    req_valid = 1'b1;
    @(posedge clk); #1;
    if (hold) drive_junk(); else req_valid = 1'b0;
    c = 1; done_at = 0; strobes = 0; proto_err = 0; got_shifted = '0;
    while (done_at == 0 && c < 200) begin
      idx = c - SHIFT_BASE;
      ct = (norm && idx >= 0) ? (idx >= ct_at) : 1'($urandom);
      @(negedge clk);
      if (done) begin
        done_at = c;
        got_shifted = shifted;
        if (n_se !== 1'b1 || alu_we !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) proto_err++;
      end else begin
        if (n_se === 1'b0) strobes++;
        if (alu_we !== ~n_se) proto_err++;
        if (busy !== 1'b1 || req_ready !== 1'b0 || n_ce_m !== 1'b1) proto_err++;
        if (c >= SHIFT_BASE) begin
          if (i_bus !== {CIN, op, cond} || n_oe_ct !== ~norm || n_ce_u !== 1'b1) proto_err++;
        end else begin
          if (i_bus !== 13'd0 || n_ce_u !== 1'b0 || n_se !== 1'b1) proto_err++;
        end
      end
      @(posedge clk); #1;
      if (hold) drive_junk();
      c++;
    end
    ct = 1'b0;
    exp_shifted = exp_q.pop_front();
    check_eq("done_seen", {31'd0, done_at != 0}, 32'd1);
    check_eq("latency", done_at, exp_n + 1 + SHIFT_BASE);
    check_eq("strobes", strobes, exp_n);
    check_eq("shifted", got_shifted, exp_shifted);
    check_eq("protocol", proto_err, 0);
    @(negedge clk);
    check_eq("idle_ready", {30'd0, req_ready, busy}, 32'd2);
    check_eq("shifted_held", shifted, exp_shifted);
  endtask

  initial begin
    logic [4:0] ops[3];
    logic [CNT_W-1:0] cnt;
    int n, err;
    ops[0] = SH_UP_ZERO; ops[1] = SH_UP_ROT; ops[2] = SH_DN_ZERO;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready_busy_done", {29'd0, req_ready, busy, done}, 32'd4);
    check_eq("rst_I", i_bus, 0);
    check_eq("rst_strobes", {27'd0, n_se, n_ce_m, n_ce_u, n_oe_ct, alu_we}, 32'b11110);
    check_eq("rst_shifted", shifted, 0);
    reset = 1'b0;
    @(negedge clk);

    run_shift(SH_UP_ZERO, 6'd5, 1'b0, 6'h00, 0, 1'b0);
    run_shift(SH_UP_ROT, 6'd0, 1'b0, CT_MN, 0, 1'b0);
    run_shift(SH_UP_ZERO, 6'd31, 1'b1, CT_NMN, 3, 1'b0);
    run_shift(SH_UP_ZERO, 6'd4, 1'b1, CT_MN, 0, 1'b0);
    run_shift(SH_UP_ROT, 6'd63, 1'b0, CT_MN, 0, 1'b0);
    run_shift(SH_UP_ZERO, 6'd3, 1'b0, CT_NMN, 0, 1'b1);
    run_shift(SH_UP_ROT, 6'd2, 1'b1, CT_MN, 9, 1'b1);
    req_valid = 1'b0;

    for (int k = 0; k < 24; k++) begin
      cnt = (k % 8 == 7) ? 6'd63 : CNT_W'($urandom_range(0, 12));
      run_shift(ops[$urandom_range(0, 2)], cnt, 1'($urandom_range(0, 1)),
                6'($urandom), $urandom_range(0, int'(cnt) + 2), 1'($urandom_range(0, 1)));
      req_valid = 1'b0;
    end

    // Reset mid-shift after three strobes
    req_op = SH_UP_ZERO; req_count = 6'd10; req_norm = 1'b0; req_cond = 6'h00;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(negedge clk);
      if (n_se === 1'b0) n++;
      if (n < 3) begin
        @(posedge clk); #1;
      end
    end
    check_eq("mid_strobes", n, 3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_busy_ready", {30'd0, busy, req_ready}, 32'd1);
    check_eq("mid_rst_nse_we", {30'd0, n_se, alu_we}, 32'd2);
    check_eq("mid_rst_shifted", shifted, 0);
    err = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (n_se !== 1'b1 || alu_we !== 1'b0 || busy !== 1'b0) err++;
    end
    check_eq("mid_rst_quiet", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
